// File: rtl/bar_chart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bar_chart_pkg
// | Shared widths, FSM state encoding and height clamp for the bar-chart drawer.
// | Revision: 1.0
// +----------------------------------------------------------------------------
package bar_chart_pkg;

    localparam int COORD_X_W = 9;
    localparam int COORD_Y_W = 8;
    localparam int HEIGHT_W  = 7;
    localparam int COLOUR_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_LOAD_E = 3'd2,
        ST_ERASE  = 3'd3,
        ST_LOAD_B = 3'd4,
        ST_PAINT  = 3'd5,
        ST_FIN    = 3'd6
    } state_t;

    function automatic logic [HEIGHT_W-1:0] clamp_height(
        input logic [HEIGHT_W-1:0] h,
        input logic [HEIGHT_W-1:0] max_h
    );
        return (h > max_h) ? max_h : h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bar_chart_draw_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bar_chart_draw_controller_if
// | Controller <-> plot engine / VGA adapter signal bundle.
// | Revision: 1.0
// +----------------------------------------------------------------------------
interface bar_chart_draw_controller_if;

    logic                                  eng_resetn;
    logic                                  eng_enable;
    logic [bar_chart_pkg::COORD_X_W-1:0]   eng_start_x;
    logic [bar_chart_pkg::COORD_Y_W-1:0]   eng_start_y;
    logic [bar_chart_pkg::HEIGHT_W-1:0]    eng_height;
    logic                                  eng_done;
    logic                                  plot;
    logic [bar_chart_pkg::COLOUR_W-1:0]    colour;

    modport master (
        output eng_resetn, eng_enable, eng_start_x, eng_start_y, eng_height,
        output plot, colour,
        input  eng_done
    );

    modport slave (
        input  eng_resetn, eng_enable, eng_start_x, eng_start_y, eng_height,
        input  plot, colour,
        output eng_done
    );

endinterface
`default_nettype wire

// File: rtl/bar_chart_draw_controller_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bar_slot_scheduler
// | Per-bar dirty bits and last-drawn heights; reports lowest dirty bar index.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module bar_slot_scheduler
    import bar_chart_pkg::*;
#(
    parameter int unsigned NUM_BARS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  wire logic                           clk,
    input  wire logic                           resetn,
    input  wire logic                           load,
    input  wire logic [NUM_BARS*HEIGHT_W-1:0]   new_heights,
    input  wire logic                           clear,
    input  wire logic [IDX_W-1:0]               clear_idx,
    input  wire logic [HEIGHT_W-1:0]            clear_height,
    output logic                                any_dirty,
    output logic [IDX_W-1:0]                    lowest_idx
);

    logic [NUM_BARS-1:0] r_dirty;
    logic [HEIGHT_W-1:0] r_last [NUM_BARS];

    // Reset marks every bar dirty so the first (or post-abort) draw repaints all.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dirty <= '1;
            for (int i = 0; i < int'(NUM_BARS); i++) begin
                r_last[i] <= '0;
            end
        end else begin
            if (load) begin
                for (int i = 0; i < int'(NUM_BARS); i++) begin
                    if (new_heights[i*HEIGHT_W +: HEIGHT_W] != r_last[i]) begin
                        r_dirty[i] <= 1'b1;
                    end
                end
            end
            if (clear) begin
                r_dirty[clear_idx] <= 1'b0;
                r_last[clear_idx]  <= clear_height;
            end
        end
    end

    always_comb begin
        any_dirty  = 1'b0;
        lowest_idx = '0;
        for (int i = int'(NUM_BARS) - 1; i >= 0; i--) begin
            if (r_dirty[i]) begin
                any_dirty  = 1'b1;
                lowest_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bar_chart_draw_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bar_chart_draw_controller
// | Sequences the plot engine to erase and repaint each changed bar of a chart.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module bar_chart_draw_controller
    import bar_chart_pkg::*;
#(
    parameter int unsigned          NUM_BARS  = 4,
    parameter int unsigned          BASE_X    = 40,
    parameter int unsigned          BAR_PITCH = 16,
    parameter int unsigned          BASE_Y    = 120,
    parameter int unsigned          MAX_H     = 100,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR = 3'b000
) (
    input  wire logic                           clk,
    input  wire logic                           resetn,
    input  wire logic                           start,
    input  wire logic [NUM_BARS*HEIGHT_W-1:0]   heights,
    input  wire logic [COLOUR_W-1:0]            bar_colour,
    output logic                                busy,
    output logic                                done,
    bar_chart_draw_controller_if.master         bus
);

    localparam int unsigned          c_idx_w   = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam logic [HEIGHT_W-1:0]  c_max_h   = HEIGHT_W'(MAX_H);
    localparam logic [COORD_Y_W-1:0] c_base_y  = COORD_Y_W'(BASE_Y);
    localparam logic [COORD_Y_W-1:0] c_floor_y = COORD_Y_W'(BASE_Y + MAX_H);

    state_t                     r_state;
    state_t                     w_next;
    logic [HEIGHT_W-1:0]        r_h [NUM_BARS];
    logic [COLOUR_W-1:0]        r_colour;
    logic [c_idx_w-1:0]         r_idx;

    logic [NUM_BARS*HEIGHT_W-1:0] w_clamped;
    logic                       w_accept;
    logic                       w_any_dirty;
    logic [c_idx_w-1:0]         w_lowest;
    logic [HEIGHT_W-1:0]        w_cur_h;
    logic [COORD_X_W-1:0]       w_x;
    logic [COORD_Y_W-1:0]       w_y_bar;

    for (genvar i = 0; i < int'(NUM_BARS); i++) begin : g_clamp
        assign w_clamped[i*HEIGHT_W +: HEIGHT_W] =
            clamp_height(heights[i*HEIGHT_W +: HEIGHT_W], c_max_h);
    end

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_cur_h  = r_h[r_idx];
    assign w_x      = COORD_X_W'(BASE_X + 32'(r_idx) * BAR_PITCH);
    assign w_y_bar  = c_floor_y - {1'b0, w_cur_h};

    bar_slot_scheduler #(
        .NUM_BARS (NUM_BARS),
        .IDX_W    (c_idx_w)
    ) u_sched (
        .clk          (clk),
        .resetn       (resetn),
        .load         (w_accept),
        .new_heights  (w_clamped),
        .clear        ((r_state == ST_PAINT) && bus.eng_done),
        .clear_idx    (r_idx),
        .clear_height (w_cur_h),
        .any_dirty    (w_any_dirty),
        .lowest_idx   (w_lowest)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NUM_BARS); i++) begin
                r_h[i] <= '0;
            end
            r_colour <= BG_COLOUR;
            r_idx    <= '0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < int'(NUM_BARS); i++) begin
                    r_h[i] <= w_clamped[i*HEIGHT_W +: HEIGHT_W];
                end
                r_colour <= bar_colour;
            end
            if (r_state == ST_SCAN) begin
                r_idx <= w_lowest;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SCAN;
            ST_SCAN:   w_next = w_any_dirty ? ST_LOAD_E : ST_FIN;
            ST_LOAD_E: w_next = ST_ERASE;
            ST_ERASE:  if (bus.eng_done) w_next = ST_LOAD_B;
            ST_LOAD_B: w_next = ST_PAINT;
            ST_PAINT:  if (bus.eng_done) w_next = ST_SCAN;
            ST_FIN:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Coordinates are held through the drawing state that follows each LOAD.
    always_comb begin
        bus.eng_resetn  = 1'b0;
        bus.eng_enable  = 1'b0;
        bus.eng_start_x = '0;
        bus.eng_start_y = '0;
        bus.eng_height  = '0;
        bus.colour      = BG_COLOUR;
        busy            = (r_state != ST_IDLE);
        done            = 1'b0;
        case (r_state)
            ST_LOAD_E, ST_ERASE: begin
                bus.eng_start_x = w_x;
                bus.eng_start_y = c_base_y;
                bus.eng_height  = c_max_h;
                if (r_state == ST_ERASE) begin
                    bus.eng_resetn = 1'b1;
                    bus.eng_enable = 1'b1;
                end
            end
            ST_LOAD_B, ST_PAINT: begin
                bus.eng_start_x = w_x;
                bus.eng_start_y = w_y_bar;
                bus.eng_height  = w_cur_h;
                if (r_state == ST_PAINT) begin
                    bus.eng_resetn = 1'b1;
                    bus.eng_enable = 1'b1;
                    bus.colour     = r_colour;
                end
            end
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

    assign bus.plot = bus.eng_enable & ~bus.eng_done;

endmodule
`default_nettype wire
